// File: rtl/rv_pkg.sv
// Shared definitions for the execute/memory boundary: datapath widths, the
// skid-buffer occupancy states and the packed EX/MEM payload.
package rv_pkg;

   localparam int XLEN  = 32;
   localparam int RADDR = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic [XLEN-1:0]  result;
      logic             of;
      logic [RADDR-1:0] rd;
      logic             we;
      logic             mem_re;
      logic             mem_we;
      logic [XLEN-1:0]  store_data;
   } ex_mem_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry skid buffer: a head register feeding the consumer and a
// skid register that absorbs the one entry in flight when the consumer stalls.
module pipe_skid_buf
   import rv_pkg::*;
#(
   parameter int W = 8
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_flush,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [W-1:0] i_data,
   output logic        o_valid,
   input  logic        i_ready,
   output logic [W-1:0] o_data,
   output logic [W-1:0] o_skid_data,
   output skid_state_e o_state
);

   skid_state_e  state_p1, state_nxt;
   logic         rdy_p1;
   logic [W-1:0] head_p1, skid_p1;
   logic         accept, drain;
   logic         load_head, load_skid, head_from_skid;

   assign accept = i_valid && rdy_p1;
   assign drain  = (state_p1 != EMPTY) && i_ready;

   always_comb begin
      state_nxt      = state_p1;
      load_head      = 1'b0;
      load_skid      = 1'b0;
      head_from_skid = 1'b0;
      if (i_flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state_p1)
            EMPTY: begin
               if (accept) begin
                  load_head = 1'b1;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (accept && drain) begin
                  load_head = 1'b1;
               end else if (accept) begin
                  load_skid = 1'b1;
                  state_nxt = TWO;
               end else if (drain) begin
                  state_nxt = EMPTY;
               end
            end
            TWO: begin
               if (drain) begin
                  head_from_skid = 1'b1;
                  state_nxt      = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // ---- control stage: occupancy and registered ready ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_p1 <= EMPTY;
         rdy_p1   <= 1'b1;
      end else begin
         state_p1 <= state_nxt;
         rdy_p1   <= (state_nxt != TWO);
      end
   end

   // ---- payload stage: head and skid entries ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         head_p1 <= '0;
         skid_p1 <= '0;
      end else begin
         if (load_head)
            head_p1 <= i_data;
         else if (head_from_skid)
            head_p1 <= skid_p1;
         if (load_skid)
            skid_p1 <= i_data;
      end
   end

   assign o_ready     = rdy_p1;
   assign o_valid     = (state_p1 != EMPTY);
   assign o_data      = head_p1;
   assign o_skid_data = skid_p1;
   assign o_state     = state_p1;

endmodule

// File: rtl/ex_mem_reg.sv
// Execute-to-memory pipeline register with x0 write masking; the operand
// bypass port is built only when EX_MEM_FWD_EN is defined.
module ex_mem_reg
   import rv_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [XLEN-1:0]  i_result,
   input  logic             i_of,
   input  logic [RADDR-1:0] i_rd,
   input  logic             i_we,
   input  logic             i_mem_re,
   input  logic             i_mem_we,
   input  logic [XLEN-1:0]  i_store_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [XLEN-1:0]  o_result,
   output logic [RADDR-1:0] o_rd,
   output logic             o_we,
   output logic             o_mem_re,
   output logic             o_mem_we,
   output logic [XLEN-1:0]  o_store_data,
   output logic             o_of
`ifdef EX_MEM_FWD_EN
   ,
   output logic             o_fwd_valid,
   output logic [RADDR-1:0] o_fwd_rd,
   output logic [XLEN-1:0]  o_fwd_data
`endif
);

   localparam int PW = $bits(ex_mem_t);

   ex_mem_t     in_p0, head_p1, skid_p1;
   skid_state_e state_p1;

   // x0 is masked here so neither writeback nor bypass ever sees it
   always_comb begin
      in_p0            = '0;
      in_p0.result     = i_result;
      in_p0.of         = i_of;
      in_p0.rd         = i_rd;
      in_p0.we         = i_we && (i_rd != '0);
      in_p0.mem_re     = i_mem_re;
      in_p0.mem_we     = i_mem_we;
      in_p0.store_data = i_store_data;
   end

   pipe_skid_buf #(.W(PW)) u_skid (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (i_flush),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_data      (in_p0),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_data      (head_p1),
      .o_skid_data (skid_p1),
      .o_state     (state_p1)
   );

   assign o_result     = head_p1.result;
   assign o_of         = head_p1.of;
   assign o_rd         = head_p1.rd;
   assign o_we         = head_p1.we;
   assign o_mem_re     = head_p1.mem_re;
   assign o_mem_we     = head_p1.mem_we;
   assign o_store_data = head_p1.store_data;

`ifdef EX_MEM_FWD_EN
   ex_mem_t youngest;

   // youngest entry only; an older head is never used as a fallback
   assign youngest    = (state_p1 == TWO) ? skid_p1 : head_p1;
   assign o_fwd_valid = (state_p1 != EMPTY) && youngest.we;
   assign o_fwd_rd    = youngest.rd;
   assign o_fwd_data  = youngest.result;
`else
   logic fwd_unused;
   assign fwd_unused = ^{skid_p1, state_p1};
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Directed bench for ex_mem_reg: reset, streaming, stall/skid, x0 masking,
// flush, overflow tagging and (when EX_MEM_FWD_EN is defined) bypass select.
module tb_ex_mem_reg;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush, in_valid, in_ready;
   logic        out_ready, out_valid;
   logic [31:0] result, store_data, o_result, o_store_data;
   logic        of_in, we, mem_re, mem_we;
   logic [4:0]  rd, o_rd;
   logic        o_we, o_mem_re, o_mem_we, o_of;
`ifdef EX_MEM_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
`endif

   int nchecks = 0;
   int nerr    = 0;

   always #5 clk = ~clk;

   ex_mem_reg dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_flush      (flush),
      .i_valid      (in_valid),
      .o_ready      (out_ready),
      .i_result     (result),
      .i_of         (of_in),
      .i_rd         (rd),
      .i_we         (we),
      .i_mem_re     (mem_re),
      .i_mem_we     (mem_we),
      .i_store_data (store_data),
      .o_valid      (out_valid),
      .i_ready      (in_ready),
      .o_result     (o_result),
      .o_rd         (o_rd),
      .o_we         (o_we),
      .o_mem_re     (o_mem_re),
      .o_mem_we     (o_mem_we),
      .o_store_data (o_store_data),
      .o_of         (o_of)
`ifdef EX_MEM_FWD_EN
      ,
      .o_fwd_valid  (fwd_valid),
      .o_fwd_rd     (fwd_rd),
      .o_fwd_data   (fwd_data)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] r, input logic [4:0] d, input logic w,
                       input logic o, input logic re, input logic mw, input logic [31:0] sd);
      in_valid   = 1'b1;
      result     = r;
      rd         = d;
      we         = w;
      of_in      = o;
      mem_re     = re;
      mem_we     = mw;
      store_data = sd;
   endtask

   task automatic idle();
      in_valid   = 1'b0;
      result     = 32'h0;
      rd         = 5'd0;
      we         = 1'b0;
      of_in      = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      store_data = 32'h0;
   endtask

   initial begin
      rst_n    = 1'b0;
      flush    = 1'b0;
      in_ready = 1'b1;
      idle();
      repeat (3) step();
      chk("rst_valid", out_valid, 1'b0);
      chk("rst_ready", out_ready, 1'b1);
      chk("rst_result", o_result, 32'h0);
      chk("rst_rd", o_rd, 5'd0);
      chk("rst_we", o_we, 1'b0);
`ifdef EX_MEM_FWD_EN
      chk("rst_fwd_valid", fwd_valid, 1'b0);
`endif
      rst_n = 1'b1;
      step();

      // single push
      push(32'h0000_00A5, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      idle();
      chk("single_valid", out_valid, 1'b1);
      chk("single_result", o_result, 32'h0000_00A5);
      chk("single_rd", o_rd, 5'd3);
      chk("single_we", o_we, 1'b1);
      step();
      chk("single_empty", out_valid, 1'b0);
      chk("single_ready", out_ready, 1'b1);

      // back-to-back stream, no bubbles
      for (int i = 1; i <= 8; i++) begin
         push(i, 5'(i), 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
         step();
         chk("stream_valid", out_valid, 1'b1);
         chk("stream_result", o_result, i);
         chk("stream_ready", out_ready, 1'b1);
      end
      idle();
      step();
      chk("stream_end", out_valid, 1'b0);

      // stall: second entry lands in skid, ready drops
      in_ready = 1'b0;
      push(32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk("stall_a_ready", out_ready, 1'b1);
      chk("stall_a_result", o_result, 32'h11);
      push(32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      idle();
      chk("stall_b_ready", out_ready, 1'b0);
      chk("stall_b_result", o_result, 32'h11);
      step();
      chk("stall_hold_valid", out_valid, 1'b1);
      chk("stall_hold_result", o_result, 32'h11);
      in_ready = 1'b1;
      step();
      chk("drain_b_result", o_result, 32'h22);
      chk("drain_b_rd", o_rd, 5'd2);
      chk("drain_b_ready", out_ready, 1'b1);
      step();
      chk("drain_empty", out_valid, 1'b0);

      // x0 destination: write enable masked
      push(32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      idle();
      chk("x0_valid", out_valid, 1'b1);
      chk("x0_result", o_result, 32'hDEAD_BEEF);
      chk("x0_we", o_we, 1'b0);
`ifdef EX_MEM_FWD_EN
      chk("x0_fwd_valid", fwd_valid, 1'b0);
`endif
      step();

      // flush in TWO with an offered entry on the same edge
      in_ready = 1'b0;
      push(32'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      push(32'h44, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      chk("pre_flush_ready", out_ready, 1'b0);
      flush = 1'b1;
      push(32'h55, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      flush = 1'b0;
      idle();
      chk("flush_valid", out_valid, 1'b0);
      chk("flush_ready", out_ready, 1'b1);
      in_ready = 1'b1;
      step();
      chk("flush_dropped", out_valid, 1'b0);

      // overflow flag tags only its own entry; memory controls pass through
      push(32'h8000_0000, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      step();
      chk("of_set", o_of, 1'b1);
      chk("of_result", o_result, 32'h8000_0000);
      chk("of_mem_re", o_mem_re, 1'b1);
      push(32'h12, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
      step();
      idle();
      chk("of_clear", o_of, 1'b0);
      chk("st_result", o_result, 32'h12);
      chk("st_mem_we", o_mem_we, 1'b1);
      chk("st_mem_re", o_mem_re, 1'b0);
      chk("st_data", o_store_data, 32'hCAFE_F00D);
      step();

      // bypass: head rd5 0x66, skid rd5 0x77
      in_ready = 1'b0;
      push(32'h66, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
`ifdef EX_MEM_FWD_EN
      chk("fwd_one_valid", fwd_valid, 1'b1);
      chk("fwd_one_data", fwd_data, 32'h66);
`endif
      push(32'h77, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      idle();
      chk("byp_head_result", o_result, 32'h66);
`ifdef EX_MEM_FWD_EN
      chk("fwd_two_valid", fwd_valid, 1'b1);
      chk("fwd_two_rd", fwd_rd, 5'd5);
      chk("fwd_two_data", fwd_data, 32'h77);
`endif
      in_ready = 1'b1;
      step();
      chk("byp_drain_result", o_result, 32'h77);
      step();
      chk("byp_empty", out_valid, 1'b0);
`ifdef EX_MEM_FWD_EN
      chk("fwd_empty_valid", fwd_valid, 1'b0);
`endif

      // youngest has we=0: no fallback to head
      in_ready = 1'b0;
      push(32'h66, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      push(32'h88, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step();
      idle();
      chk("nofb_head_we", o_we, 1'b1);
`ifdef EX_MEM_FWD_EN
      chk("nofb_fwd_valid", fwd_valid, 1'b0);
`endif

      // asynchronous reset mid-operation drops everything at once
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", out_valid, 1'b0);
      chk("arst_ready", out_ready, 1'b1);
      chk("arst_result", o_result, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("arst_after_valid", out_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchecks);
      $finish;
   end

endmodule
